// File: rtl/multicycle_cpu.sv
// Multicycle LEGv8 subset core: FETCH/DECODE/EXECUTE/MEM/WB over one shared
// instruction/data memory port with a req/ready handshake.
module multicycle_cpu #(
    parameter int              XLEN            = 64,
    parameter logic [XLEN-1:0] RESET_PC        = '0,
    parameter bit              HALT_ON_ILLEGAL = 1'b1
) (
    input  logic            clock,
    input  logic            reset,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ready,
    output logic [XLEN-1:0] pc,
    output logic            halted,
    output logic [31:0]     retire_count,
    output logic [2:0]      state
);
    localparam logic [2:0] S_FETCH   = 3'd0;
    localparam logic [2:0] S_DECODE  = 3'd1;
    localparam logic [2:0] S_EXECUTE = 3'd2;
    localparam logic [2:0] S_MEM     = 3'd3;
    localparam logic [2:0] S_WB      = 3'd4;
    localparam logic [2:0] S_HALT    = 3'd5;

    logic [31:0]     ir;
    logic [XLEN-1:0] fpc, a, b, alu_out, mdr;
    logic [XLEN-1:0] regs [32];
    logic [XLEN-1:0] rn_val, rm_val, rt_val, alu_res;
    logic [XLEN-1:0] imm_mem, imm_cbz, imm_b;
    logic            is_ldur, is_stur, is_add, is_sub, is_and, is_orr, is_cbz, is_b;
    logic            is_rtype, legal;

    assign is_ldur  = (ir[31:21] == 11'b11111000010);
    assign is_stur  = (ir[31:21] == 11'b11111000000);
    assign is_add   = (ir[31:21] == 11'b10001011000);
    assign is_sub   = (ir[31:21] == 11'b11001011000);
    assign is_and   = (ir[31:21] == 11'b10001010000);
    assign is_orr   = (ir[31:21] == 11'b10101010000);
    assign is_cbz   = (ir[31:24] == 8'b10110100);
    assign is_b     = (ir[31:26] == 6'b000101);
    assign is_rtype = is_add | is_sub | is_and | is_orr;
    assign legal    = is_rtype | is_ldur | is_stur | is_cbz | is_b;

    assign imm_mem = {{(XLEN-9){ir[20]}}, ir[20:12]};
    assign imm_cbz = {{(XLEN-21){ir[23]}}, ir[23:5], 2'b00};
    assign imm_b   = {{(XLEN-28){ir[25]}}, ir[25:0], 2'b00};

    // X31 is the zero register on every read port
    assign rn_val = (ir[9:5]   == 5'd31) ? '0 : regs[ir[9:5]];
    assign rm_val = (ir[20:16] == 5'd31) ? '0 : regs[ir[20:16]];
    assign rt_val = (ir[4:0]   == 5'd31) ? '0 : regs[ir[4:0]];

    always_comb begin
        alu_res = a + b;
        if (is_sub)      alu_res = a - b;
        else if (is_and) alu_res = a & b;
        else if (is_orr) alu_res = a | b;
    end

    // Request is a pure function of state so mem_ready never reaches mem_req
    assign mem_req   = reset && ((state == S_FETCH) || (state == S_MEM));
    assign mem_we    = reset && (state == S_MEM) && is_stur;
    assign mem_addr  = (state == S_MEM) ? alu_out : pc;
    assign mem_wdata = b;
    assign halted    = (state == S_HALT);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= S_FETCH;
            pc           <= RESET_PC;
            ir           <= '0;
            fpc          <= '0;
            a            <= '0;
            b            <= '0;
            alu_out      <= '0;
            mdr          <= '0;
            retire_count <= '0;
            for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
        end else begin
            case (state)
                S_FETCH: if (mem_ready) begin
                    ir    <= mem_rdata[31:0];
                    fpc   <= pc;
                    pc    <= pc + XLEN'(4);
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    a <= rn_val;
                    b <= is_rtype ? rm_val : rt_val;
                    if (legal) state <= S_EXECUTE;
                    else if (HALT_ON_ILLEGAL) state <= S_HALT;
                    else begin
                        retire_count <= retire_count + 32'd1;
                        state        <= S_FETCH;
                    end
                end
                S_EXECUTE: begin
                    if (is_rtype) begin
                        alu_out <= alu_res;
                        state   <= S_WB;
                    end else if (is_ldur || is_stur) begin
                        alu_out <= a + imm_mem;
                        state   <= S_MEM;
                    end else begin
                        if (is_cbz && (b == '0)) pc <= fpc + imm_cbz;
                        else if (is_b)           pc <= fpc + imm_b;
                        retire_count <= retire_count + 32'd1;
                        state        <= S_FETCH;
                    end
                end
                S_MEM: if (mem_ready) begin
                    if (is_stur) begin
                        retire_count <= retire_count + 32'd1;
                        state        <= S_FETCH;
                    end else begin
                        mdr   <= mem_rdata;
                        state <= S_WB;
                    end
                end
                S_WB: begin
                    if (ir[4:0] != 5'd31) regs[ir[4:0]] <= is_ldur ? mdr : alu_out;
                    retire_count <= retire_count + 32'd1;
                    state        <= S_FETCH;
                end
                S_HALT: state <= S_HALT;
                default: state <= S_HALT;
            endcase
        end
    end
endmodule
